// File: rtl/updown_counter_p.sv
// updown_counter_p -- modulo-(MAX_VAL+1) up/down counter with load, wrap or saturate, and
// overflow/underflow flags.
//
// Parameters:
//   WIDTH   : counter width in bits (2..32)
//   MAX_VAL : top count; the counter runs modulo MAX_VAL+1
//   STEP    : amount added or subtracted on each enabled cycle (1..MAX_VAL)
//
// Ports:
//   clk       : clock, all state changes on the rising edge
//   rst       : asynchronous active-low reset (c, ovf, unf -> 0)
//   en        : count enable
//   up        : direction, 1 = up, 0 = down
//   load      : synchronous load strobe, has priority over en
//   load_val  : value to load, clamped to MAX_VAL
//   sat_mode  : 1 = saturate at the bounds, 0 = wrap
//   clr_flags : clears sticky ovf/unf (ignored unless sticky flags are built in)
//   c         : registered count
//   tc        : terminal count, combinational (c at the bound in the current direction)
//   ovf       : registered overflow flag
//   unf       : registered underflow flag
//
// Build option:
//   UPDN_STICKY_FLAGS_EN defined   : ovf/unf hold until clr_flags; a new event on the same
//                                    edge as clr_flags wins.
//   UPDN_STICKY_FLAGS_EN undefined : ovf/unf are one-cycle pulses after the event edge.

module updown_counter_p #(
   parameter int unsigned      WIDTH   = 8,
   parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
   parameter logic [WIDTH-1:0] STEP    = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             sat_mode,
   input  logic             clr_flags,
   output logic [WIDTH-1:0] c,
   output logic             tc,
   output logic             ovf,
   output logic             unf
);

   logic [WIDTH-1:0] r_c;
   logic             r_ovf;
   logic             r_unf;

   // All range arithmetic is done one bit wider so c+STEP and MAX_VAL+1 cannot overflow.
   logic [WIDTH:0] w_one;
   logic [WIDTH:0] w_c_ext;
   logic [WIDTH:0] w_max_ext;
   logic [WIDTH:0] w_step_ext;
   logic [WIDTH:0] w_ld_ext;
   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_up_wrap;
   logic [WIDTH:0] w_dn_wrap;
   logic           w_up_over;
   logic           w_dn_under;
   logic [WIDTH:0] w_c_nxt_ext;
   logic           w_ovf_evt;
   logic           w_unf_evt;
   logic           w_unused;

   assign w_one      = {{WIDTH{1'b0}}, 1'b1};
   assign w_c_ext    = {1'b0, r_c};
   assign w_max_ext  = {1'b0, MAX_VAL};
   assign w_step_ext = {1'b0, STEP};
   assign w_ld_ext   = {1'b0, load_val};

   assign w_sum      = w_c_ext + w_step_ext;
   assign w_up_over  = (w_sum > w_max_ext);
   assign w_dn_under = (w_c_ext < w_step_ext);
   // Wrapped results: c+STEP-(MAX_VAL+1) going up, c+(MAX_VAL+1)-STEP going down.
   assign w_up_wrap  = w_sum - w_max_ext - w_one;
   assign w_dn_wrap  = w_c_ext + w_max_ext + w_one - w_step_ext;

   always_comb begin
      w_c_nxt_ext = w_c_ext;
      w_ovf_evt   = 1'b0;
      w_unf_evt   = 1'b0;
      if (load) begin
         w_c_nxt_ext = (w_ld_ext > w_max_ext) ? w_max_ext : w_ld_ext;
      end else if (en) begin
         if (up) begin
            if (w_up_over) begin
               w_ovf_evt   = 1'b1;
               w_c_nxt_ext = sat_mode ? w_max_ext : w_up_wrap;
            end else begin
               w_c_nxt_ext = w_sum;
            end
         end else begin
            if (w_dn_under) begin
               w_unf_evt   = 1'b1;
               w_c_nxt_ext = sat_mode ? '0 : w_dn_wrap;
            end else begin
               w_c_nxt_ext = w_c_ext - w_step_ext;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_c   <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         r_c <= w_c_nxt_ext[WIDTH-1:0];
`ifdef UPDN_STICKY_FLAGS_EN
         // Set wins over clear so an event coinciding with clr_flags is not lost.
         r_ovf <= w_ovf_evt | (r_ovf & ~clr_flags);
         r_unf <= w_unf_evt | (r_unf & ~clr_flags);
`else
         r_ovf <= w_ovf_evt;
         r_unf <= w_unf_evt;
`endif
      end
   end

   // Top bit of the next value is always 0 (result <= MAX_VAL); clr_flags is only
   // consumed in the sticky build.
   assign w_unused = ^{clr_flags, w_c_nxt_ext[WIDTH]};

   assign c   = r_c;
   assign ovf = r_ovf;
   assign unf = r_unf;
   assign tc  = up ? (r_c == MAX_VAL) : (r_c == '0);

endmodule

// File: doc/updown_counter_p.md
UPDOWN_COUNTER_P -- requirements
Module: updown_counter_p

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter width in bits; legal range 2 to 32.
REQ-002 SHALL have parameter MAX_VAL, default 2**WIDTH-1: top count, modulus MAX_VAL+1; legal range 1 to 2**WIDTH-1.
REQ-003 SHALL have parameter STEP, default 1: increment/decrement per enabled cycle; legal range 1 to MAX_VAL.
REQ-004 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port en, input, 1: count enable.
REQ-007 SHALL have port up, input, 1: direction, 1 = count up, 0 = count down.
REQ-008 SHALL have port load, input, 1: synchronous load strobe.
REQ-009 SHALL have port load_val, input, WIDTH: value to load.
REQ-010 SHALL have port sat_mode, input, 1: 1 = saturate at bounds, 0 = wrap.
REQ-011 SHALL have port clr_flags, input, 1: clears sticky flags (see Configuration).
REQ-012 SHALL have port c, output, WIDTH: registered count.
REQ-013 SHALL have port tc, output, 1: terminal count, combinational.
REQ-014 SHALL have port ovf, output, 1: overflow flag, registered.
REQ-015 SHALL have port unf, output, 1: underflow flag, registered.

Function
REQ-016 SHALL apply priority load > en > hold on each rising clk edge.
REQ-017 load=1 SHALL set c to load_val, clamped to MAX_VAL if load_val > MAX_VAL; no ovf/unf event; en ignored.
REQ-018 en=0 and load=0 SHALL hold c unchanged.
REQ-019 SHALL do up-count arithmetic in WIDTH+1 bits; if c+STEP <= MAX_VAL, c becomes c+STEP.
REQ-020 If c+STEP > MAX_VAL: sat_mode=0 SHALL give c = c+STEP-(MAX_VAL+1); sat_mode=1 SHALL give c = MAX_VAL. Both SHALL raise an overflow event.
REQ-021 Down count: if c >= STEP, c becomes c-STEP.
REQ-022 If c < STEP: sat_mode=0 SHALL give c = c+(MAX_VAL+1)-STEP; sat_mode=1 SHALL give c = 0. Both SHALL raise an underflow event.
REQ-023 At c=MAX_VAL counting up, or c=0 counting down, in saturate mode, SHALL hold c and still raise the event.
REQ-024 SHALL sample up and sat_mode every cycle; a direction change takes effect on the same edge, with no pipeline bubble.
REQ-025 tc SHALL be 1 when (up=1 and c=MAX_VAL) or (up=0 and c=0), independent of en.
REQ-026 Latency: c, ovf and unf SHALL update one edge after the sampled inputs.

Reset
REQ-027 rst=0 SHALL immediately force c=0, ovf=0 and unf=0, regardless of clk.
REQ-028 Assertion mid-count SHALL discard any in-progress load or count; the first update SHALL occur on the first rising edge with rst=1.
REQ-029 After reset, tc SHALL follow REQ-025 (tc=1 when up=0, since c=0).

Configuration
REQ-030 Macro UPDN_STICKY_FLAGS_EN defined: ovf/unf SHALL set on their event and hold until clr_flags=1; event and clr_flags on the same edge leaves the flag set.
REQ-031 Macro undefined: ovf/unf SHALL be single-cycle pulses, high for the one cycle after the event edge; clr_flags SHALL be ignored.

Verification
REQ-032 Defaults, reset then en=1, up=1, sat_mode=0 for 256 cycles -> c steps 0..255 then 0; ovf event at 255->0; tc=1 while c=255.
REQ-033 MAX_VAL=9, STEP=3, load 8, up=1, sat_mode=0 -> c=1 with ovf; repeat with sat_mode=1 -> c=9, ovf, held on further counts.
REQ-034 MAX_VAL=9, STEP=3, c=1, up=0 -> wrap gives c=8 with unf; saturate gives c=0 with unf.
REQ-035 load=1 and en=1 with load_val=200, MAX_VAL=150 -> c=150, no flag; rst low mid-count -> c=0 asynchronously, before the next edge.
REQ-036 Flags: run with and without UPDN_STICKY_FLAGS_EN -> without: ovf pulses one cycle; with: ovf persists until clr_flags, and clr_flags coinciding with a new overflow leaves ovf=1.
